// File: rtl/bram_arb_pkg.sv
// Shared types for the audio BRAM port-B arbiter: FSM states, requester ids
// and the response tag that follows each issued beat.
package bram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam logic REQ_CODEC = 1'b0;
  localparam logic REQ_DEBUG = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } rsp_tag_t;

endpackage

// File: rtl/bram_rsp_tag_pipe.sv
// Delay line carrying the {valid, id} tag of every issued beat until its read
// data leaves the BRAM, so the top level can steer rsp_rdata to its owner.
module bram_rsp_tag_pipe
  import bram_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk_in,
  input  logic     rst_n,
  input  rsp_tag_t push_tag,
  output rsp_tag_t tail_tag,
  output logic     any_valid
);

  rsp_tag_t [DEPTH-1:0] stage_q;
  rsp_tag_t [DEPTH-1:0] stage_d;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = push_tag;
    for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_valid = any_valid | stage_q[i].valid;
  end

  assign tail_tag = stage_q[DEPTH-1];

  // NOTE: this tag array is reset, unlike a data RAM: a stale valid bit would emit a response after reset.
  always_ff @(posedge clk_in or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!rst_n) stage_q <= '0;
    else        stage_q <= stage_d;
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin burst arbiter sharing BRAM port B between the compression engine
// (requester 0) and the debug dump reader (requester 1), with tagged read returns.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int RD_LATENCY   = 1,
  parameter int MAX_BURST    = 16,
  parameter int HOLD_TIMEOUT = 8
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                req0_valid,
  input  logic [DATA_W/8-1:0] req0_we,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_wdata,
  input  logic                req0_last,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [DATA_W/8-1:0] req1_we,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_wdata,
  input  logic                req1_last,
  output logic                req1_ready,
  output logic                rsp0_valid,
  output logic                rsp1_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  input  logic [DATA_W-1:0]   doutb,
  output logic                rstb,
  output logic                enb,
  output logic [DATA_W/8-1:0] web,
  output logic [ADDR_W-1:0]   addrb,
  output logic [DATA_W-1:0]   dinb,
  output logic [1:0]          grant,
  output logic                busy
);

  localparam int BE_W   = DATA_W / 8;
  localparam int BCNT_W = $clog2(MAX_BURST + 1);
  localparam int ICNT_W = $clog2(HOLD_TIMEOUT + 1);

  arb_state_e        state_q, state_d;
  logic              rr_q, rr_d;
  logic [BCNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [ICNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              enb_q, enb_d;
  logic [BE_W-1:0]   web_q, web_d;
  logic [ADDR_W-1:0] addrb_q, addrb_d;
  logic [DATA_W-1:0] dinb_q, dinb_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;

  logic              owner;
  logic              sel_valid, sel_last, accept, drop_grant;
  logic [BE_W-1:0]   sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  rsp_tag_t          push_tag, tail_tag;
  logic              pipe_busy;

  always_comb begin
    owner     = (state_q == GNT1);
    sel_valid = owner ? req1_valid : req0_valid;
    sel_last  = owner ? req1_last  : req0_last;
    sel_we    = owner ? req1_we    : req0_we;
    sel_addr  = owner ? req1_addr  : req0_addr;
    sel_wdata = owner ? req1_wdata : req0_wdata;
    accept    = (state_q != IDLE) && sel_valid;

    state_d    = state_q;
    rr_d       = rr_q;
    beat_cnt_d = beat_cnt_q;
    idle_cnt_d = idle_cnt_q;
    drop_grant = 1'b0;

    // Port pins are registered; address and write data hold between beats.
    enb_d   = accept;
    web_d   = accept ? sel_we : '0;
    addrb_d = accept ? (sel_addr & ~ADDR_W'(3)) : addrb_q;
    dinb_d  = accept ? sel_wdata : dinb_q;

    push_tag = '{valid: accept && (sel_we == '0), id: owner};

    case (state_q)
      IDLE: begin
        beat_cnt_d = '0;
        idle_cnt_d = '0;
        if (req0_valid && req1_valid) state_d = rr_q ? GNT1 : GNT0;
        else if (req0_valid)          state_d = GNT0;
        else if (req1_valid)          state_d = GNT1;
      end
      default: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + BCNT_W'(1);
          idle_cnt_d = '0;
          drop_grant = sel_last || (beat_cnt_d == BCNT_W'(MAX_BURST));
        end else begin
          idle_cnt_d = idle_cnt_q + ICNT_W'(1);
          drop_grant = (idle_cnt_d == ICNT_W'(HOLD_TIMEOUT));
        end
        if (drop_grant) begin
          state_d = IDLE;
          rr_d    = ~owner;
        end
      end
    endcase

    rsp0_valid_d = tail_tag.valid && (tail_tag.id == REQ_CODEC);
    rsp1_valid_d = tail_tag.valid && (tail_tag.id == REQ_DEBUG);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_q         <= REQ_CODEC;
      beat_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      enb_q        <= 1'b0;
      web_q        <= '0;
      addrb_q      <= '0;
      dinb_q       <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      beat_cnt_q   <= beat_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      enb_q        <= enb_d;
      web_q        <= web_d;
      addrb_q      <= addrb_d;
      dinb_q       <= dinb_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  // The extra register after the tail lines the response up with doutb.
  bram_rsp_tag_pipe #(
    .DEPTH(RD_LATENCY + 1)
  ) u_tag_pipe (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .push_tag (push_tag),
    .tail_tag (tail_tag),
    .any_valid(pipe_busy)
  );

  assign req0_ready = (state_q == GNT0);
  assign req1_ready = (state_q == GNT1);
  assign grant      = {state_q == GNT1, state_q == GNT0};
  assign busy       = (state_q != IDLE) || pipe_busy;
  assign rstb       = 1'b0;
  assign enb        = enb_q;
  assign web        = web_q;
  assign addrb      = addrb_q;
  assign dinb       = dinb_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp_rdata  = doutb;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomized bench for bram_port_arbiter: a BRAM model on port B plus a
// transaction-level reference of grants, port writes and tagged read returns.
module tb_bram_port_arbiter;
  import bram_arb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int RL     = 1;
  localparam int MAXB   = 16;
  localparam int HOLD   = 8;
  localparam int WORDS  = 64;

  logic              clk_in = 1'b0;
  logic              rst_n  = 1'b1;
  logic              req0_valid, req0_last, req1_valid, req1_last;
  logic [BE_W-1:0]   req0_we, req1_we;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [DATA_W-1:0] req0_wdata, req1_wdata;
  logic              req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [DATA_W-1:0] rsp_rdata, doutb, dinb;
  logic              rstb, enb, busy;
  logic [BE_W-1:0]   web;
  logic [ADDR_W-1:0] addrb;
  logic [1:0]        grant;

  always #5 clk_in = ~clk_in;

  bram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RL),
    .MAX_BURST(MAXB), .HOLD_TIMEOUT(HOLD)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_last(req1_last), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_rdata(rsp_rdata),
    .doutb(doutb), .rstb(rstb), .enb(enb), .web(web), .addrb(addrb),
    .dinb(dinb), .grant(grant), .busy(busy)
  );

  // BRAM model: samples the port at an edge, data appears RL edges later plus the output stage
  logic [DATA_W-1:0] bram_mem [WORDS];
  logic [DATA_W-1:0] rd_pipe  [RL];
  always @(posedge clk_in) begin
    logic [DATA_W-1:0] word;
    word = bram_mem[addrb[7:2]];
    if (enb)
      for (int b = 0; b < BE_W; b++)
        if (web[b]) bram_mem[addrb[7:2]][8*b +: 8] <= dinb[8*b +: 8];
    rd_pipe[0] <= word;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    doutb <= rd_pipe[RL-1];
  end

  // Reference model state
  typedef struct { int due; int id; logic [DATA_W-1:0] data; } rsp_exp_t;
  logic [DATA_W-1:0] ref_mem [WORDS];
  rsp_exp_t          pend [$];
  int                m_owner, m_rr, m_beats, m_idle;
  bit                exp_enb;
  logic [BE_W-1:0]   exp_web;
  logic [ADDR_W-1:0] exp_addrb;
  logic [DATA_W-1:0] exp_dinb;
  int                cyc;
  bit                acc [2];

  // Requester stimulus state
  int                r_left [2];
  int                r_pct  [2];
  bit                r_lastmode [2];
  logic [BE_W-1:0]   r_we   [2];
  logic [ADDR_W-1:0] r_addr [2];
  logic [DATA_W-1:0] r_wdata [2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_beats = 0; m_idle = 0;
    exp_enb = 0; exp_web = '0; exp_addrb = '0; exp_dinb = '0;
    pend.delete();
  endtask

  task automatic check_outputs();
    logic [1:0] g;
    bit r0, r1, bz;
    g = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    check("grant", grant, g);
    check("req0_ready", req0_ready, m_owner == 0);
    check("req1_ready", req1_ready, m_owner == 1);
    check("rstb", rstb, 0);
    check("enb", enb, exp_enb);
    check("web", web, exp_web);
    check("addrb", addrb, exp_addrb);
    check("dinb", dinb, exp_dinb);
    r0 = 0; r1 = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      if (pend[0].id == 0) r0 = 1; else r1 = 1;
      check("rsp_rdata", rsp_rdata, pend[0].data);
      void'(pend.pop_front());
    end
    check("rsp0_valid", rsp0_valid, r0);
    check("rsp1_valid", rsp1_valid, r1);
    bz = (m_owner >= 0);
    foreach (pend[i]) if (pend[i].due - 1 - RL <= cyc) bz = 1;
    check("busy", busy, bz);
  endtask

  // Advance the model across the next rising edge, clock the DUT, then compare
  task automatic tick();
    bit v [2];
    bit l [2];
    logic [BE_W-1:0]   we [2];
    logic [ADDR_W-1:0] ad [2];
    logic [DATA_W-1:0] wd [2];
    int n;
    v[0] = req0_valid; l[0] = req0_last; we[0] = req0_we; ad[0] = req0_addr; wd[0] = req0_wdata;
    v[1] = req1_valid; l[1] = req1_last; we[1] = req1_we; ad[1] = req1_addr; wd[1] = req1_wdata;
    acc[0] = 0; acc[1] = 0;
    if (rst_n) begin
      if (m_owner < 0) begin
        exp_enb = 0; exp_web = '0; m_beats = 0; m_idle = 0;
        if (v[0] && v[1]) m_owner = m_rr;
        else if (v[0])    m_owner = 0;
        else if (v[1])    m_owner = 1;
      end else begin
        n = m_owner;
        if (v[n]) begin
          acc[n]    = 1;
          exp_enb   = 1;
          exp_web   = we[n];
          exp_addrb = {ad[n][ADDR_W-1:2], 2'b00};
          exp_dinb  = wd[n];
          if (we[n] == '0)
            pend.push_back('{due: cyc + 2 + RL, id: n, data: ref_mem[ad[n][7:2]]});
          else
            for (int b = 0; b < BE_W; b++)
              if (we[n][b]) ref_mem[ad[n][7:2]][8*b +: 8] = wd[n][8*b +: 8];
          m_beats++; m_idle = 0;
          if (l[n] || m_beats == MAXB) begin m_owner = -1; m_rr = 1 - n; end
        end else begin
          exp_enb = 0; exp_web = '0; m_idle++;
          if (m_idle == HOLD) begin m_owner = -1; m_rr = 1 - n; end
        end
      end
    end
    @(posedge clk_in);
    cyc++;
    @(negedge clk_in);
    check_outputs();
  endtask

  task automatic apply_inputs();
    bit v [2];
    bit l [2];
    for (int n = 0; n < 2; n++) begin
      v[n] = (r_left[n] > 0) && ($urandom_range(99) < r_pct[n]);
      l[n] = r_lastmode[n] && (r_left[n] == 1);
    end
    req0_valid = v[0]; req0_last = l[0]; req0_we = r_we[0]; req0_wdata = r_wdata[0];
    req0_addr  = r_addr[0] | ADDR_W'($urandom_range(3));
    req1_valid = v[1]; req1_last = l[1]; req1_we = r_we[1]; req1_wdata = r_wdata[1];
    req1_addr  = r_addr[1] | ADDR_W'($urandom_range(3));
  endtask

  task automatic step();
    apply_inputs();
    tick();
    for (int n = 0; n < 2; n++)
      if (acc[n]) begin
        r_left[n]--;
        r_addr[n]  += 4;
        r_wdata[n] = $urandom();
      end
  endtask

  task automatic start(input int n, input int len, input logic [BE_W-1:0] we,
                       input logic [ADDR_W-1:0] addr, input bit lastmode,
                       input int pct, input logic [DATA_W-1:0] wdata);
    r_left[n] = len; r_we[n] = we; r_addr[n] = addr;
    r_lastmode[n] = lastmode; r_pct[n] = pct; r_wdata[n] = wdata;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int k = 0;
    while ((r_left[0] > 0 || r_left[1] > 0) && k < budget) begin
      step();
      k++;
    end
    check({tag, "_done"}, r_left[0] + r_left[1], 0);
    r_left[0] = 0; r_left[1] = 0;
    repeat (HOLD + RL + 4) step();
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    r_left[0] = 0; r_left[1] = 0;
    req0_valid = 0; req1_valid = 0; req0_last = 0; req1_last = 0;
    #1;
    model_reset();
    check_outputs();
    repeat (hold) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    int n_acc, k;
    cyc = 0;
    for (int i = 0; i < WORDS; i++) begin
      ref_mem[i]  = 32'hA500_0000 | (i * 32'h0001_0203);
      bram_mem[i] <= 32'hA500_0000 | (i * 32'h0001_0203);
    end
    for (int n = 0; n < 2; n++) start(n, 0, '0, '0, 1'b1, 100, '0);
    req0_valid = 0; req1_valid = 0; req0_last = 0; req1_last = 0;
    req0_we = '0; req1_we = '0; req0_addr = '0; req1_addr = '0;
    req0_wdata = '0; req1_wdata = '0;
    #2;
    do_reset(3);

    // Debug reader: 4-beat read burst from 0x00
    start(1, 4, 4'h0, 32'h0, 1'b1, 100, '0);
    run_until_done("single_read", 40);

    // Simultaneous requests, twice: round-robin alternates the winner
    start(0, 3, 4'h0, 32'h40, 1'b1, 100, '0);
    start(1, 3, 4'h0, 32'h80, 1'b1, 100, '0);
    run_until_done("contention_a", 60);
    start(0, 2, 4'h0, 32'h40, 1'b1, 100, '0);
    start(1, 2, 4'h0, 32'h80, 1'b1, 100, '0);
    run_until_done("contention_b", 60);

    // Burst cap: 40 beats without last, alone and against an interleaving reader
    start(0, 40, 4'h0, 32'h0, 1'b0, 100, '0);
    run_until_done("cap_alone", 200);
    start(0, 40, 4'h0, 32'h0, 1'b0, 100, '0);
    start(1, 10, 4'h0, 32'h20, 1'b1, 100, '0);
    run_until_done("cap_shared", 300);

    // Hold timeout: two beats then silence; the reader must wait for release
    start(0, 2, 4'h0, 32'h30, 1'b0, 100, '0);
    run_until_done("hold_a", 20);
    start(0, 2, 4'h0, 32'h30, 1'b0, 100, '0);
    k = 0;
    while (r_left[0] > 0 && k < 20) begin step(); k++; end
    start(1, 3, 4'h0, 32'h60, 1'b1, 100, '0);
    run_until_done("hold_b", 60);

    // Write then read back the same word; then a beat at the top of the address space
    start(0, 1, 4'hF, 32'h10, 1'b1, 100, 32'hDEAD_BEEF);
    run_until_done("write", 20);
    start(0, 1, 4'h0, 32'h10, 1'b1, 100, '0);
    run_until_done("readback", 20);
    start(1, 1, 4'h0, 32'hFFFF_FFFC, 1'b1, 100, '0);
    run_until_done("top_addr", 20);

    // Reset one cycle after the third read accept, then contend again
    start(1, 8, 4'h0, 32'h20, 1'b1, 100, '0);
    n_acc = 0; k = 0;
    while (n_acc < 3 && k < 40) begin
      step();
      if (acc[1]) n_acc++;
      k++;
    end
    check("rst_third_accept", n_acc, 3);
    step();
    do_reset(2);
    start(0, 2, 4'h0, 32'h50, 1'b1, 100, '0);
    start(1, 2, 4'h0, 32'h70, 1'b1, 100, '0);
    run_until_done("post_reset", 60);

    // Random traffic
    for (int t = 0; t < 500; t++) begin
      for (int n = 0; n < 2; n++)
        if (r_left[n] == 0 && $urandom_range(7) == 0)
          start(n, $urandom_range(20, 1),
                (n == 0 && $urandom_range(1) == 1) ? 4'($urandom_range(15, 1)) : 4'h0,
                ADDR_W'($urandom_range(WORDS - 1)) << 2, $urandom_range(4) != 0,
                $urandom_range(100, 40), $urandom());
      step();
    end
    r_left[0] = 0; r_left[1] = 0;
    repeat (HOLD + RL + 6) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Shares the single 32-bit port B of the audio BRAM between two requesters: requester 0, the compression engine (read/write), and requester 1, the debug dump reader (read-only in practice). Bursts are granted round-robin and drive the BRAM port-B pins from registers. Read data returns with a tag so each requester sees only its own responses. The block sits between both requesters and the BRAM instance and replaces direct port-B wiring.

## Interface
- ADDR_W, 32, byte-address width of addrb
- DATA_W, 32, data width (web is DATA_W/8 bits)
- RD_LATENCY, 1, BRAM read latency in clk_in edges; legal values 1 or 2
- MAX_BURST, 16, maximum beats per grant
- HOLD_TIMEOUT, 8, consecutive idle cycles (valid low) before a held grant is released
- clk_in  in  1  clock; all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- reqN_valid  in  1  beat request, N in {0,1}
- reqN_we  in  DATA_W/8  byte write enables; 0 means read
- reqN_addr  in  ADDR_W  byte address; bits [1:0] ignored and forced to 0
- reqN_wdata  in  DATA_W  write data
- reqN_last  in  1  final beat of the burst
- reqN_ready  out  1  beat accepted this cycle when valid&ready
- rspN_valid  out  1  rsp_rdata belongs to requester N this cycle
- rsp_rdata  out  DATA_W  BRAM doutb passthrough
- doutb  in  DATA_W  BRAM read data
- rstb, enb  out  1  BRAM controls; rstb tied 0
- web  out  DATA_W/8  BRAM byte write enable
- addrb  out  ADDR_W  BRAM byte address
- dinb  out  DATA_W  BRAM write data
- grant  out  2  one-hot current owner; 0 in IDLE
- busy  out  1  state != IDLE or response pipe non-empty

## Operation
- States: IDLE, GNT0, GNT1.
- IDLE: if exactly one requester has valid, go to its GNTn. If both are valid, go to the one selected by the rr pointer. Otherwise stay in IDLE.
- GNTn: reqN_ready = 1 (combinational from state); other requester's ready = 0.
- On each accepted beat, register enb=1, web=reqN_we, addrb={addr[ADDR_W-1:2],2'b00}, dinb=wdata. Otherwise register enb=0 and web=0; addrb and dinb hold their values.
- A beat counter (clears on grant) counts accepted beats. Leave GNTn for IDLE after an accepted beat with last=1, or when the counter reaches MAX_BURST.
- An idle counter counts consecutive cycles in GNTn with valid=0. Leave GNTn for IDLE when it reaches HOLD_TIMEOUT. An accepted beat clears it.
- On leaving GNTn, the rr pointer is set to the other requester.
- Read beats (we==0) push {1, id} into a tag pipe. Write beats push {0, x}.
- Write beats produce no response.
- Reset value of every output is 0: enb, web, addrb, dinb, grant, busy, rspN_valid, reqN_ready. rstb is constant 0. The rr pointer resets to requester 0; both counters reset to 0.

## Timing
- Arbitration: valid first seen in IDLE at edge k gives grant at k+1. Ready is high in cycle k+1..k+2, so the first acceptance is at edge k+2.
- There is at least one IDLE cycle between consecutive grants.
- A beat accepted at edge a drives enb high during cycle a..a+1, and the BRAM samples it at a+1.
- rspN_valid is asserted during cycle a+1+RD_LATENCY..a+2+RD_LATENCY, aligned with doutb.
- The tag pipe depth is RD_LATENCY+1. It keeps draining after the grant ends and through IDLE.
- Back-to-back accepts give one beat per cycle. MAX_BURST=16 means at most 16 consecutive enb cycles per grant.
- If valid drops mid-burst, the grant is held; accepted beats stay contiguous in order with no reordering.
- When last=1 and beat count = MAX_BURST fall on the same beat, the grant is released once and the rr pointer advances once.
- reqN_addr near the top of the address space has no wrap checking; the address passes through.
- Asserting rst_n low mid-burst clears the state and the tag pipe immediately. In-flight read responses are dropped; no rspN_valid follows reset release.

## Structure
- Package bram_arb_pkg holds:
  - state enum (IDLE, GNT0, GNT1)
  - requester id constants REQ_CODEC=0 and REQ_DEBUG=1
  - tag struct {valid, id}
- One sub-module, bram_rsp_tag_pipe: a parameterised shift register of tags, depth RD_LATENCY+1, with async clear.
- Counters live in the top level.

## Test plan
- Single read burst: req1 reads 4 beats at 0x00,0x04,0x08,0x0C with last on the 4th.
  - Expect enb high 4 consecutive cycles and addrb 0x00..0x0C.
  - Expect rsp1_valid 4 cycles, starting 2 cycles after the first accept (RD_LATENCY=1), data matching the preloaded BRAM words.
  - Expect rsp0_valid to stay 0.
- Contention: both valid in the same IDLE cycle after reset.
  - Expect requester 0 granted first; after its last beat, one IDLE cycle, then GNT1.
  - Repeat the same contention: expect GNT1 first.
- Burst cap: req0 valid for 40 beats with last never set. Expect grants of 16, 16, then 8 beats (the last ended by timeout or last), with one IDLE cycle between them. Test both with req1 idle and with req1 interleaving.
- Hold timeout: req0 sends 2 beats, then drops valid for 8 cycles. Expect grant released after the 8th idle cycle, and req1 granted on the next arbitration.
- Write/read mix: req0 writes 0xDEADBEEF with we=4'hF at 0x10, then reads 0x10. Expect web=4'hF for one cycle, then a single rsp0_valid with rsp_rdata=0xDEADBEEF.
- Reset mid-burst: pull rst_n low one cycle after the 3rd read accept. Expect all outputs 0 immediately, no rspN_valid after release, and requester 0 has priority on the next contention.
